// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Default number of BCD digits (matches the 4-digit display driver)
    localparam int DIGITS_DEF = 4;

    // 10^n, usable in constant expressions
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest value representable in DIGITS_DEF decimal digits
    localparam longint unsigned BCD_MAX = pow10(DIGITS_DEF) - 64'd1;

    // Saturation pattern: every nibble is 9
    localparam logic [DIGITS_DEF*4-1:0] BCD_SAT = {DIGITS_DEF{4'h9}};

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - combinational double-dabble cell: add 3 when the nibble is 5 or more
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A nibble of 5..9 would exceed 9 after doubling; pre-adding 3 makes the shift carry correctly
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter (optional BIN2BCD_SAT_EN saturation)
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  ovf
);

    // Scratch layout: [extra top nibble | DIGITS BCD nibbles | binary being shifted out]
    localparam int SCR_W = DIGITS*4 + 4 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(pow10(DIGITS) - 64'd1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [SCR_W-1:0]     scratch;
    logic [SCR_W-1:0]     adj;
    logic                 ovf_pend;
    logic [DIGITS*4-1:0]  result;

    // Add-3 correction on every BCD nibble, including the extra top one
    for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (scratch[BIN_W + 4*g +: 4]),
            .dout (adj[BIN_W + 4*g +: 4])
        );
    end

    // The binary field passes through the correction untouched
    assign adj[BIN_W-1:0] = scratch[BIN_W-1:0];

`ifdef BIN2BCD_SAT_EN
    localparam logic [DIGITS*4-1:0] SAT_VAL = {DIGITS{4'h9}};

    // Over-range inputs clamp to all nines
    assign result = ovf_pend ? SAT_VAL : scratch[BIN_W +: DIGITS*4];
`else
    // Over-range inputs wrap: the extra top nibble is simply dropped
    assign result = scratch[BIN_W +: DIGITS*4];
`endif

    assign in_ready = (state == IDLE);

    // Control FSM, scratch datapath and held result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            scratch   <= '0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        scratch  <= {{(DIGITS*4 + 4){1'b0}}, bin_in};
                        cnt      <= '0;
                        ovf_pend <= (bin_in > MAX_BIN);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= adj << 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out   <= result;
                    ovf       <= ovf_pend;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
